// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: issues req/ack fetches,
// applies taken redirects with a timed flush, and latches fatal fetch errors.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        next_pc_src,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        flush,
  output logic        fetch_err
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, FLUSH, ERR} state_e;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [8:0] TO_LIMIT   = 9'(ACK_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req_q, req_d;
  logic        vld_q, vld_d;
  logic        discard_q, discard_d;
  logic        err_q, err_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;

  logic        redirect, misaligned, ack_any, slot_free, completed, timeout;
  logic [8:0]  to_next;

  always_comb begin
    redirect   = br_valid && next_pc_src;
    misaligned = br_target[1:0] != 2'b00;
    ack_any    = req_q && imem_ack;
    // An ack is only taken when the decode slot can receive it; a held,
    // stalled instruction keeps the request pending instead of being overwritten.
    slot_free  = !vld_q || !stall;
    completed  = ack_any && (discard_q || slot_free);
    to_next    = {1'b0, to_cnt_q} + 9'd1;
    timeout    = req_q && !imem_ack && (to_next >= TO_LIMIT);

    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    req_d       = req_q;
    vld_d       = vld_q && stall;
    discard_d   = discard_q;
    err_d       = err_q;
    flush_cnt_d = flush_cnt_q;
    to_cnt_d    = (req_q && !imem_ack) ? to_next[7:0] : 8'd0;

    if (state_q == ERR) begin
      req_d       = 1'b0;
      vld_d       = 1'b0;
      discard_d   = 1'b0;
      flush_cnt_d = 3'd0;
      to_cnt_d    = 8'd0;
    end else if ((redirect && misaligned) || timeout) begin
      state_d     = ERR;
      err_d       = 1'b1;
      req_d       = 1'b0;
      vld_d       = 1'b0;
      discard_d   = 1'b0;
      flush_cnt_d = 3'd0;
      to_cnt_d    = 8'd0;
    end else if (redirect) begin
      // An in-flight request is allowed to finish but its data is dropped.
      state_d     = FLUSH;
      pc_d        = br_target;
      vld_d       = 1'b0;
      flush_cnt_d = FLUSH_INIT;
      if (ack_any) begin
        req_d     = 1'b0;
        discard_d = 1'b0;
      end else begin
        discard_d = req_q;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (!stall) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (completed) begin
            discard_d = 1'b0;
            if (!discard_q) begin
              inst_d    = imem_rdata;
              inst_pc_d = pc_q;
              vld_d     = 1'b1;
              pc_d      = pc_q + 32'd4;
            end
            if (!stall) begin
              addr_d = pc_d;
            end else begin
              req_d   = 1'b0;
              state_d = FETCH;
            end
          end
        end
        FLUSH: begin
          if (completed) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
          end
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1) begin
            state_d = (req_q && !completed) ? WAIT : FETCH;
          end
        end
        default: state_d = ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
      req_q       <= 1'b0;
      vld_q       <= 1'b0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
      flush_cnt_q <= 3'd0;
      to_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      req_q       <= req_d;
      vld_q       <= vld_d;
      discard_q   <= discard_d;
      err_q       <= err_d;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = vld_q;
  assign flush      = flush_cnt_q != 3'd0;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by a randomized
// run checked against a program-order / flush-window reference model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RPC2      = 32'hFFFF_FFF8;
  localparam int          FLUSH_N   = 2;
  localparam int          RND_CYCLES = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        br_valid, next_pc_src, stall, imem_ack;
  logic [31:0] br_target;
  logic        imem_req, inst_valid, flush, fetch_err;
  logic [31:0] imem_addr, imem_rdata, inst_out, inst_pc;

  logic        req2, vld2, flush2, err2;
  logic [31:0] addr2, rdata2, inst2, ipc2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign rdata2     = mem_word(addr2);

  pc_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .next_pc_src(next_pc_src),
    .br_target(br_target), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .flush(flush), .fetch_err(fetch_err)
  );

  pc_fetch_sequencer #(.RESET_PC(RPC2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .br_valid(1'b0), .next_pc_src(1'b0),
    .br_target(32'h0), .stall(1'b0), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(rdata2), .inst_out(inst2), .inst_pc(ipc2),
    .inst_valid(vld2), .flush(flush2), .fetch_err(err2)
  );

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic s, input logic a, input logic bv, input logic ns,
                     input logic [31:0] t);
    stall       = s;
    imem_ack    = a;
    br_valid    = bv;
    next_pc_src = ns;
    br_target   = t;
  endtask

  // Asserts reset between edges, checks the asynchronous reset values, and
  // releases so that the next rising edge is cycle 1.
  task automatic do_reset(input string tag);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk({tag, "_req"},   imem_req,   32'h0);
    chk({tag, "_addr"},  imem_addr,  32'h0);
    chk({tag, "_inst"},  inst_out,   32'h0);
    chk({tag, "_ipc"},   inst_pc,    32'h0);
    chk({tag, "_vld"},   inst_valid, 32'h0);
    chk({tag, "_flush"}, flush,      32'h0);
    chk({tag, "_err"},   fetch_err,  32'h0);
    chk({tag, "_addr2"}, addr2,      RPC2);
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_tbl [4];
    logic [31:0] exp_pc, p_out, p_pc, p_addr, tgt;
    logic        p_vld, p_stall, p_req, p_ack, p_redir, s, a, redir, nps0, exp_flush;
    int          flush_left, wait_n;

    wrap_tbl[0] = 32'hFFFF_FFF8;
    wrap_tbl[1] = 32'hFFFF_FFFC;
    wrap_tbl[2] = 32'h0000_0000;
    wrap_tbl[3] = 32'h0000_0004;

    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;

    // Zero-wait memory: sequential addresses, one instruction per cycle.
    do_reset("rst0");
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) chk("t1_idle_noreq", imem_req, 32'h0);
      if (k >= 2 && k <= 5) begin
        chk("t1_req", imem_req, 32'h1);
        chk("t1_addr", imem_addr, 32'(4 * (k - 2)));
        chk("t6_addr_wrap", addr2, wrap_tbl[k - 2]);
      end
      if (k >= 3) begin
        chk("t1_vld", inst_valid, 32'h1);
        chk("t1_ipc", inst_pc, 32'(4 * (k - 3)));
        chk("t1_inst", inst_out, mem_word(32'(4 * (k - 3))));
        chk("t6_ipc_wrap", ipc2, wrap_tbl[k - 3]);
        chk("t6_inst_wrap", inst2, mem_word(wrap_tbl[k - 3]));
        chk("t6_vld", vld2, 32'h1);
      end
      chk("t6_noflush_noerr", {flush2, err2}, 32'h0);
      drv(1'b0, imem_req, 1'b0, 1'b0, 32'h0);
    end

    // Ack delayed three cycles, then stall holds the delivered instruction.
    do_reset("rst2");
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("t2_req_held", imem_req, 32'h1);
      chk("t2_addr_stable", imem_addr, 32'h0);
      chk("t2_no_vld", inst_valid, 32'h0);
      if (k < 5) drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      else       drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    tick();
    chk("t2_vld", inst_valid, 32'h1);
    chk("t2_ipc", inst_pc, 32'h0);
    chk("t2_inst", inst_out, mem_word(32'h0));
    chk("t2_noreq_stall1", imem_req, 32'h0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t2_vld_hold", inst_valid, 32'h1);
    chk("t2_inst_hold", inst_out, mem_word(32'h0));
    chk("t2_noreq_stall2", imem_req, 32'h0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t2_req_resume", imem_req, 32'h1);
    chk("t2_addr_next", imem_addr, 32'h4);
    chk("t2_consumed", inst_valid, 32'h0);

    // Taken redirect while the fetch of 0x8 is outstanding.
    do_reset("rst3");
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t3_addr8", imem_addr, 32'h8);
    chk("t3_ipc4", inst_pc, 32'h4);
    drv(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    tick();
    chk("t3_flush1", flush, 32'h1);
    chk("t3_req_outstanding", imem_req, 32'h1);
    chk("t3_addr_kept", imem_addr, 32'h8);
    chk("t3_vld_killed", inst_valid, 32'h0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t3_flush2", flush, 32'h1);
    chk("t3_discarded", inst_valid, 32'h0);
    chk("t3_req_done", imem_req, 32'h0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t3_flush_end", flush, 32'h0);
    chk("t3_vld_after_flush", inst_valid, 32'h0);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t3_req_target", imem_req, 32'h1);
    chk("t3_addr_target", imem_addr, 32'h100);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t3_vld_target", inst_valid, 32'h1);
    chk("t3_ipc_target", inst_pc, 32'h100);
    chk("t3_inst_target", inst_out, mem_word(32'h100));

    // Not-taken branch is ignored; misaligned taken target is fatal.
    do_reset("rst4");
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t4_ipc0", inst_pc, 32'h0);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
    tick();
    chk("t4_nottaken_ipc", inst_pc, 32'h4);
    chk("t4_nottaken_addr", imem_addr, 32'h8);
    chk("t4_nottaken_flush", flush, 32'h0);
    drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
    tick();
    chk("t4_err", fetch_err, 32'h1);
    chk("t4_req_off", imem_req, 32'h0);
    chk("t4_vld_off", inst_valid, 32'h0);
    chk("t4_flush_off", flush, 32'h0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_req_stays_off", imem_req, 32'h0);
      chk("t4_err_sticky", fetch_err, 32'h1);
    end

    // Ack never arrives: error after 15 waiting cycles, cleared by reset.
    do_reset("rst5");
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 2; k <= 17; k++) begin
      tick();
      if (k <= 16) begin
        chk("t5_waiting_req", imem_req, 32'h1);
        chk("t5_no_err_yet", fetch_err, 32'h0);
      end else begin
        chk("t5_timeout_err", fetch_err, 32'h1);
        chk("t5_timeout_req", imem_req, 32'h0);
      end
    end
    do_reset("rst5b");
    tick();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t5_resume_req", imem_req, 32'h1);
    chk("t5_resume_addr", imem_addr, 32'h0);
    chk("t5_resume_err", fetch_err, 32'h0);

    // Randomized traffic against the program-order reference.
    do_reset("rst7");
    exp_pc     = 32'h0;
    flush_left = 0;
    wait_n     = 0;
    p_vld = 1'b0; p_stall = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_redir = 1'b0;
    p_out = 32'h0; p_pc = 32'h0; p_addr = 32'h0;
    for (int c = 0; c < RND_CYCLES; c++) begin
      tick();
      exp_flush = flush_left > 0;
      if (flush_left > 0) flush_left--;
      chk("rnd_err", fetch_err, 32'h0);
      chk("rnd_flush", flush, 32'(exp_flush));
      if (exp_flush) chk("rnd_flush_novld", inst_valid, 32'h0);
      if (p_redir) chk("rnd_redir_kill", inst_valid, 32'h0);
      if (p_req && !p_ack) begin
        chk("rnd_req_held", imem_req, 32'h1);
        chk("rnd_addr_stable", imem_addr, p_addr);
      end
      if (p_vld && p_stall && !p_redir) begin
        chk("rnd_hold_vld", inst_valid, 32'h1);
        chk("rnd_hold_inst", inst_out, p_out);
        chk("rnd_hold_ipc", inst_pc, p_pc);
      end else if (inst_valid) begin
        chk("rnd_ipc", inst_pc, exp_pc);
        chk("rnd_inst", inst_out, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end

      s     = $urandom_range(0, 9) < 3;
      redir = $urandom_range(0, 99) < 4;
      nps0  = !redir && ($urandom_range(0, 99) < 5);
      if (imem_req) wait_n++;
      else          wait_n = 0;
      if (imem_req) a = ($urandom_range(0, 9) < 6) || (wait_n > 6);
      else          a = $urandom_range(0, 9) == 0;
      if (a) wait_n = 0;
      if (redir) begin
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
        else                           tgt = 32'($urandom_range(0, 255)) << 2;
        exp_pc     = tgt;
        flush_left = FLUSH_N;
      end else begin
        tgt = $urandom();
      end
      drv(s, a, redir || nps0, redir, tgt);

      p_redir = redir;
      p_req   = imem_req;
      p_ack   = a;
      p_addr  = imem_addr;
      p_vld   = inst_valid;
      p_stall = s;
      p_out   = inst_out;
      p_pc    = inst_pc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
